// File: rtl/mem_dcache_ctrl_pkg.sv
// Shared constants and FSM encoding for the MEM-stage data cache.
package mem_dcache_ctrl_pkg;
  localparam int DCACHE_LINE_NUM      = 64;
  localparam int DCACHE_DATA_BIT      = 64;
  localparam int DCACHE_SRAM_DATA_BIT = 256;
  localparam int DCACHE_RAM_DATA_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_REFILL = 2'd2,
    ST_RFWAIT = 2'd3
  } dc_state_e;
endpackage

// File: rtl/mem_dcache_ctrl_line_ram.sv
// Data/tag/valid/dirty storage for the direct-mapped cache.
// Async read by index; sync byte-masked word write; whole-line fill port.
module mem_dcache_ctrl_line_ram #(
  parameter int LINE_NUM = 64,
  parameter int LINE_BIT = 256,
  parameter int DATA_BIT = 64,
  parameter int TAG_BIT  = 5,
  localparam int IDX_BIT = $clog2(LINE_NUM),
  localparam int SEL_BIT = $clog2(LINE_BIT / DATA_BIT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [IDX_BIT-1:0]    i_idx,
  input  logic                  i_wr_en,
  input  logic [SEL_BIT-1:0]    i_wr_sel,
  input  logic [DATA_BIT-1:0]   i_wr_dat,
  input  logic [DATA_BIT/8-1:0] i_wr_strb,
  input  logic                  i_fill_en,
  input  logic [TAG_BIT-1:0]    i_fill_tag,
  input  logic [LINE_BIT-1:0]   i_fill_dat,
  output logic [LINE_BIT-1:0]   o_line,
  output logic [TAG_BIT-1:0]    o_tag,
  output logic                  o_valid,
  output logic                  o_dirty
);
  logic [LINE_BIT-1:0] r_data [LINE_NUM];
  logic [TAG_BIT-1:0]  r_tag  [LINE_NUM];
  logic [LINE_NUM-1:0] r_valid;
  logic [LINE_NUM-1:0] r_dirty;

  assign o_line  = r_data[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_wr_en && (|i_wr_strb)) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid gates every use of them.
  always_ff @(posedge i_clk) begin
    if (i_fill_en) begin
      r_data[i_idx] <= i_fill_dat;
      r_tag[i_idx]  <= i_fill_tag;
    end else if (i_wr_en) begin
      for (int b = 0; b < DATA_BIT / 8; b++) begin
        if (i_wr_strb[b])
          r_data[i_idx][int'(i_wr_sel)*DATA_BIT + b*8 +: 8] <= i_wr_dat[b*8 +: 8];
      end
    end
  end
endmodule

// File: rtl/mem_dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache: zero-wait hits, misses do an
// optional dirty write-back beat then one refill beat on the shared SRAM line port.
module mem_dcache_ctrl
  import mem_dcache_ctrl_pkg::*;
#(
  parameter int RAM_DATA_SIZE = DCACHE_RAM_DATA_SIZE,
  parameter int SRAM_DATA_BIT = DCACHE_SRAM_DATA_BIT,
  parameter int LINE_NUM      = DCACHE_LINE_NUM,
  parameter int DATA_BIT      = DCACHE_DATA_BIT,
  localparam int SRAM_ADDR_BIT = RAM_DATA_SIZE - $clog2(SRAM_DATA_BIT / 8)
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_sys_n_i,
  input  logic                     cpu_req_i,
  input  logic                     cpu_we_i,
  input  logic [RAM_DATA_SIZE-1:0] cpu_addr_i,
  input  logic [DATA_BIT-1:0]      cpu_wdata_i,
  input  logic [DATA_BIT/8-1:0]    cpu_wstrb_i,
  output logic [DATA_BIT-1:0]      cpu_rdata_o,
  output logic                     cpu_ready_o,
  output logic                     MEM_SRAM_ena_o,
  output logic                     MEM_SRAM_wea_o,
  output logic [SRAM_ADDR_BIT-1:0] MEM_SRAM_addr_o,
  output logic [SRAM_DATA_BIT-1:0] MEM_SRAM_data_o,
  input  logic [SRAM_DATA_BIT-1:0] MEM_SRAM_data_i
);
  localparam int OFF_BIT = $clog2(SRAM_DATA_BIT / 8);
  localparam int IDX_BIT = $clog2(LINE_NUM);
  localparam int TAG_BIT = SRAM_ADDR_BIT - IDX_BIT;
  localparam int SEL_BIT = $clog2(SRAM_DATA_BIT / DATA_BIT);
  localparam int LSB_BIT = OFF_BIT - SEL_BIT;

  dc_state_e r_state, w_state_nxt;

  logic [IDX_BIT-1:0]       w_idx;
  logic [TAG_BIT-1:0]       w_tag;
  logic [SEL_BIT-1:0]       w_sel;
  logic [SRAM_DATA_BIT-1:0] w_line;
  logic [TAG_BIT-1:0]       w_line_tag;
  logic                     w_line_valid;
  logic                     w_line_dirty;
  logic                     w_hit;
  logic                     w_wr_en;
  logic                     w_fill_en;
  logic                     w_unused_lsb;

  assign w_idx        = cpu_addr_i[OFF_BIT +: IDX_BIT];
  assign w_tag        = cpu_addr_i[RAM_DATA_SIZE-1 -: TAG_BIT];
  assign w_sel        = cpu_addr_i[LSB_BIT +: SEL_BIT];
  assign w_unused_lsb = ^cpu_addr_i[LSB_BIT-1:0];
  assign w_hit        = cpu_req_i && w_line_valid && (w_line_tag == w_tag);

  mem_dcache_ctrl_line_ram #(
    .LINE_NUM (LINE_NUM),
    .LINE_BIT (SRAM_DATA_BIT),
    .DATA_BIT (DATA_BIT),
    .TAG_BIT  (TAG_BIT)
  ) u_line_ram (
    .i_clk      (clk_sys_i),
    .i_rst_n    (rst_sys_n_i),
    .i_idx      (w_idx),
    .i_wr_en    (w_wr_en),
    .i_wr_sel   (w_sel),
    .i_wr_dat   (cpu_wdata_i),
    .i_wr_strb  (cpu_wstrb_i),
    .i_fill_en  (w_fill_en),
    .i_fill_tag (w_tag),
    .i_fill_dat (MEM_SRAM_data_i),
    .o_line     (w_line),
    .o_tag      (w_line_tag),
    .o_valid    (w_line_valid),
    .o_dirty    (w_line_dirty)
  );

  always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
    if (!rst_sys_n_i) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Outputs decode straight from state, so reset silences the SRAM port at once.
  always_comb begin
    w_state_nxt     = r_state;
    cpu_ready_o     = 1'b0;
    cpu_rdata_o     = '0;
    MEM_SRAM_ena_o  = 1'b0;
    MEM_SRAM_wea_o  = 1'b0;
    MEM_SRAM_addr_o = '0;
    MEM_SRAM_data_o = '0;
    w_wr_en         = 1'b0;
    w_fill_en       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          cpu_ready_o = 1'b1;
          if (cpu_we_i) w_wr_en = 1'b1;
          else          cpu_rdata_o = w_line[int'(w_sel)*DATA_BIT +: DATA_BIT];
        end else if (cpu_req_i) begin
          w_state_nxt = (w_line_valid && w_line_dirty) ? ST_WB : ST_REFILL;
        end
      end
      ST_WB: begin
        MEM_SRAM_ena_o  = 1'b1;
        MEM_SRAM_wea_o  = 1'b1;
        MEM_SRAM_addr_o = {w_line_tag, w_idx};
        MEM_SRAM_data_o = w_line;
        w_state_nxt     = ST_REFILL;
      end
      ST_REFILL: begin
        MEM_SRAM_ena_o  = 1'b1;
        MEM_SRAM_addr_o = {w_tag, w_idx};
        w_state_nxt     = ST_RFWAIT;
      end
      ST_RFWAIT: begin
        w_fill_en   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end
endmodule
